sc_grid_monitor: RTL
====================

Name: sc_grid_monitor

Overview:
- Upstream conditioning stage for the smart-charging core.
- Converts raw grid measurement samples (RMS voltage code, absolute frequency deviation) into the debounced 2-bit grid_state consumed by the charging FSM.
- Adds asymmetric debounce: fast degrade, slow recovery. Adds a sample-starvation watchdog that forces the fault state when measurements stop arriving.

Parameters:
VW, 12, voltage sample width (bits)
FW, 8, frequency-deviation sample width (bits)
V_OUTAGE, 1000, voltage below this value = outage
V_NOM_LO, 3400, lower bound of nominal voltage band (inclusive)
V_NOM_HI, 3800, upper bound of nominal voltage band (inclusive)
F_TOL, 20, maximum tolerated frequency deviation (inclusive)
DEGRADE_CNT, 3, consecutive samples needed to move to a worse state (>=1)
RECOVER_CNT, 8, consecutive samples needed to move to a better state (>=1)
TIMEOUT_CYC, 1000, clock cycles without sample_valid before a forced FAULT (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sample_valid  in  1  qualifies voltage/freq_dev for one cycle
voltage  in  VW  RMS voltage code, unsigned
freq_dev  in  FW  absolute frequency deviation code, unsigned
grid_state  out  2  debounced state: 2'b00 OK, 2'b01 UNSTABLE, 2'b10 FAULT; 2'b11 never driven
state_change  out  1  one-cycle pulse when grid_state changes
sample_stale  out  1  high while the watchdog has expired and no new sample has arrived

Behaviour:
- Reset (asynchronous, reset_n=0):
  - grid_state=FAULT, state_change=0, sample_stale=0.
  - Candidate = FAULT, count = 0, watchdog timer = 0.
  - Comes up pessimistic; OK is reached only after RECOVER_CNT good samples.
- Raw classification (combinational, used only when sample_valid=1):
  - FAULT if voltage < V_OUTAGE.
  - Else UNSTABLE if voltage < V_NOM_LO, or voltage > V_NOM_HI, or freq_dev > F_TOL.
  - Else OK.
  - Boundary values V_OUTAGE, V_NOM_LO, V_NOM_HI and F_TOL all classify to the better class.
  - Severity order: OK < UNSTABLE < FAULT.
- Debounce, evaluated on each sample_valid cycle, result registered at the next clk edge:
  - raw == grid_state: count <= 0.
  - raw != grid_state and raw == candidate: count <= count+1, saturating at max(DEGRADE_CNT, RECOVER_CNT).
  - raw != grid_state and raw != candidate: candidate <= raw, count <= 1.
  - Commit when the new count reaches the threshold: DEGRADE_CNT if candidate is worse than grid_state, RECOVER_CNT if better.
  - On commit: grid_state <= candidate, count <= 0, state_change <= 1 for exactly one cycle.
  - Direct jumps OK<->FAULT are allowed. Any interrupting different class restarts the count.
  - Latency: grid_state updates on the edge ending the sample_valid cycle that completes the threshold. With DEGRADE_CNT=1 this is one cycle after the sample.
- Cycles without sample_valid:
  - Debounce state holds.
  - Watchdog timer increments, saturating.
- Watchdog:
  - Any sample_valid cycle resets the timer to 0 and clears sample_stale on the next edge.
  - When the timer reaches TIMEOUT_CYC-1 with sample_valid=0 (i.e. the TIMEOUT_CYC-th empty cycle), the following edge does:
    - sample_stale <= 1, grid_state <= FAULT, candidate <= FAULT, count <= 0.
    - state_change pulses only if grid_state was not already FAULT.
  - Timeout fires once per starvation period; the timer saturates and no repeat pulse is generated.
  - If sample_valid and the timeout coincide, the sample wins: no timeout, normal debounce.
  - After a timeout, recovery follows normal debounce from FAULT.
- state_change is a pure registered pulse. It is never high on two consecutive cycles unless two commits occur on consecutive sample_valid cycles.
- Reset asserted mid-debounce or mid-timeout returns immediately to reset values. No partial count survives.
- Counter widths are sized from $clog2 of the largest threshold / TIMEOUT_CYC. No overflow is possible because all counters saturate.

Test Plan:
- Reset release, 8 samples at voltage=3600, freq_dev=5 -> grid_state stays 2'b10 through the 7th sample; 2'b00 the cycle after the 8th; one state_change pulse.
- From OK: 2 samples at voltage=3300, one sample at 3600, then 3 samples at 3300 -> no change until the 3rd consecutive 3300; then UNSTABLE, single pulse.
- Boundaries from OK: voltage=3800, freq_dev=20 x5 -> stays OK. Then voltage=999 x3 -> FAULT directly, one pulse. voltage=1000 x3 from OK -> UNSTABLE, never FAULT.
- From OK: mixed samples UNSTABLE, FAULT, UNSTABLE, FAULT... x10 -> candidate keeps restarting, grid_state remains OK, no pulse.
- From OK: stop sample_valid for 1000 cycles -> sample_stale=1 and grid_state=FAULT on the following edge, one pulse. A further 2000 idle cycles -> no further pulse. One good sample -> sample_stale=0 and grid_state still FAULT.
- Sample arriving exactly on the timeout cycle -> no forced FAULT, no stale. Assert reset_n low mid-count (count=2 toward UNSTABLE) -> immediate FAULT, stale=0, count cleared.

Source files
------------

// File: rtl/sc_grid_monitor.sv
// Grid measurement conditioner: classifies raw voltage/frequency samples, debounces
// them asymmetrically (fast degrade, slow recovery) and forces FAULT on sample starvation.
module sc_grid_monitor #(
  parameter int VW          = 12,
  parameter int FW          = 8,
  parameter int V_OUTAGE    = 1000,
  parameter int V_NOM_LO    = 3400,
  parameter int V_NOM_HI    = 3800,
  parameter int F_TOL       = 20,
  parameter int DEGRADE_CNT = 3,
  parameter int RECOVER_CNT = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sample_valid,
  input  logic [VW-1:0] voltage,
  input  logic [FW-1:0] freq_dev,
  output logic [1:0]    grid_state,
  output logic          state_change,
  output logic          sample_stale
);

  localparam int CMAX = (DEGRADE_CNT > RECOVER_CNT) ? DEGRADE_CNT : RECOVER_CNT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [VW-1:0] V_OUT_C  = VW'(V_OUTAGE);
  localparam logic [VW-1:0] V_LO_C   = VW'(V_NOM_LO);
  localparam logic [VW-1:0] V_HI_C   = VW'(V_NOM_HI);
  localparam logic [FW-1:0] F_TOL_C  = FW'(F_TOL);
  localparam logic [CW-1:0] CMAX_C   = CW'(CMAX);
  localparam logic [CW-1:0] DEG_C    = CW'(DEGRADE_CNT);
  localparam logic [CW-1:0] REC_C    = CW'(RECOVER_CNT);
  localparam logic [TW-1:0] TMAX_C   = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TFIRE_C  = TW'(TIMEOUT_CYC - 1);

  // Encoding doubles as severity order, so "worse" is a plain magnitude compare.
  typedef enum logic [1:0] {
    GS_OK       = 2'b00,
    GS_UNSTABLE = 2'b01,
    GS_FAULT    = 2'b10
  } gs_e;

  gs_e           state_q, state_d, cand_q, cand_d, raw;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          stale_q, stale_d, chg_q, chg_d;

  always_comb begin
    raw = GS_OK;
    if (voltage < V_OUT_C)
      raw = GS_FAULT;
    else if (voltage < V_LO_C || voltage > V_HI_C || freq_dev > F_TOL_C)
      raw = GS_UNSTABLE;
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    stale_d = stale_q;
    chg_d   = 1'b0;
    if (sample_valid) begin
      tmr_d   = '0;
      stale_d = 1'b0;
      if (raw == state_q) begin
        cnt_d = '0;
      end else begin
        if (raw == cand_q) begin
          cnt_d = (cnt_q == CMAX_C) ? cnt_q : cnt_q + CW'(1);
        end else begin
          cand_d = raw;
          cnt_d  = CW'(1);
        end
        if (cnt_d >= ((cand_d > state_q) ? DEG_C : REC_C)) begin
          state_d = cand_d;
          cnt_d   = '0;
          chg_d   = 1'b1;
        end
      end
    end else begin
      if (tmr_q != TMAX_C)
        tmr_d = tmr_q + TW'(1);
      // Timer parks at TMAX after firing, so starvation reports only once.
      if (tmr_q == TFIRE_C) begin
        stale_d = 1'b1;
        state_d = GS_FAULT;
        cand_d  = GS_FAULT;
        cnt_d   = '0;
        chg_d   = (state_q != GS_FAULT);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= GS_FAULT;
      cand_q  <= GS_FAULT;
      cnt_q   <= '0;
      tmr_q   <= '0;
      stale_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      stale_q <= stale_d;
      chg_q   <= chg_d;
    end
  end

  assign grid_state   = state_q;
  assign state_change = chg_q;
  assign sample_stale = stale_q;

endmodule
